// File: rtl/m_serial_alu_seq.sv
// Bit-serial ALU sequencer: processes two 32-bit operands LSB-first, one bit
// per clock, through a single-bit adder/logic slice with a carry flip-flop.
// Delivers the 32-bit result together with a one-cycle done pulse.
module m_serial_alu_seq (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_start,
  input  logic [2:0]  w_op,
  input  logic [31:0] w_a,
  input  logic [31:0] w_b,
  output logic        w_busy,
  output logic        r_done,
  output logic [31:0] r_rslt
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_SLT   = 3'b101,
    OP_SLTU  = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_e;

  state_e      state, state_nxt;
  op_e         r_op;
  logic [31:0] r_sa, r_sb, r_sr;
  logic [4:0]  r_cnt;
  logic        r_c;
  logic        r_a31, r_b31, r_d31;

  // Per-bit slice signals
  logic        is_arith, inv_b, bit_a, bit_b, bit_beff, bit_sum, bit_carry, bit_res;
  logic        last_bit;

  assign w_busy   = (state != S_IDLE);
  assign last_bit = (r_cnt == 5'd31);

  // State register
  always_ff @(posedge w_clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (w_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (w_start) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-bit ALU slice working on the current LSBs
  always_comb begin
    is_arith  = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_SLT) || (r_op == OP_SLTU);
    inv_b     = (r_op == OP_SUB) || (r_op == OP_SLT) || (r_op == OP_SLTU);
    bit_a     = r_sa[0];
    bit_b     = r_sb[0];
    bit_beff  = bit_b ^ inv_b;
    bit_sum   = bit_a ^ bit_beff ^ r_c;
    bit_carry = (bit_a & bit_beff) | (bit_a & r_c) | (bit_beff & r_c);
    bit_res   = bit_sum;
    unique case (r_op)
      OP_AND:   bit_res = bit_a & bit_b;
      OP_OR:    bit_res = bit_a | bit_b;
      OP_XOR:   bit_res = bit_a ^ bit_b;
      OP_PASSB: bit_res = bit_b;
      default:  bit_res = bit_sum;
    endcase
  end

  // Datapath: operand capture, bit-serial shifting, result commit
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      // NOTE: the shift registers are ordinary flops, not a memory array, so
      // clearing them on reset is cheap and keeps post-reset state defined.
      r_sa   <= '0;
      r_sb   <= '0;
      r_sr   <= '0;
      r_op   <= OP_ADD;
      r_cnt  <= '0;
      r_c    <= 1'b0;
      r_a31  <= 1'b0;
      r_b31  <= 1'b0;
      r_d31  <= 1'b0;
      r_rslt <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (w_start) begin
            r_sa  <= w_a;
            r_sb  <= w_b;
            r_op  <= op_e'(w_op);
            r_c   <= (w_op == OP_SUB) || (w_op == OP_SLT) || (w_op == OP_SLTU);
            r_sr  <= '0;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_sr  <= {bit_res, r_sr[31:1]};
          r_sa  <= {1'b0, r_sa[31:1]};
          r_sb  <= {1'b0, r_sb[31:1]};
          r_cnt <= r_cnt + 5'd1;
          if (is_arith) r_c <= bit_carry;
          if (last_bit) begin
            r_a31 <= bit_a;
            r_b31 <= bit_b;
            r_d31 <= bit_sum;
          end
        end
        S_FIN: begin
          unique case (r_op)
            OP_SLT:  r_rslt <= {31'b0, (r_a31 != r_b31) ? r_a31 : r_d31};
            OP_SLTU: r_rslt <= {31'b0, ~r_c};
            default: r_rslt <= r_sr;
          endcase
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_serial_alu_seq.sv
// Self-checking bench for m_serial_alu_seq: table of directed vectors plus
// hand-written sequences for busy-start, mid-operation reset and back-to-back.
module tb_m_serial_alu_seq;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic        w_start;
  logic [2:0]  w_op;
  logic [31:0] w_a, w_b;
  logic        w_busy, r_done;
  logic [31:0] r_rslt;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SLT = 3'd5, SLTU = 3'd6, PASSB = 3'd7;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  m_serial_alu_seq dut (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .w_start(w_start),
    .w_op   (w_op),
    .w_a    (w_a),
    .w_b    (w_b),
    .w_busy (w_busy),
    .r_done (r_done),
    .r_rslt (r_rslt)
  );

  always #5 w_clk = ~w_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after an edge. Start is sampled at the next edge (E0); returns
  // the edge index at which r_done was first seen, or 0 on timeout.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    w_op = op; w_a = a; w_b = b; w_start = 1'b1;
    @(posedge w_clk); #1;
    w_start = 1'b0;
    lat = 0;
    res = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge w_clk); #1;
      if (r_done) begin
        lat = i;
        res = r_rslt;
        break;
      end
    end
  endtask

  initial begin
    int          lat, lat2, pulses, busy_bad;
    logic [31:0] res;

    vecs[0]  = '{"add_5_7",      ADD,   32'd5,        32'd7,        32'd12};
    vecs[1]  = '{"add_wrap",     ADD,   32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[2]  = '{"sub_3_5",      SUB,   32'd3,        32'd5,        32'hFFFFFFFE};
    vecs[3]  = '{"slt_m1_1",     SLT,   32'hFFFFFFFF, 32'd1,        32'd1};
    vecs[4]  = '{"sltu_m1_1",    SLTU,  32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[5]  = '{"slt_min_max",  SLT,   32'h80000000, 32'h7FFFFFFF, 32'd1};
    vecs[6]  = '{"slt_eq",       SLT,   32'd9,        32'd9,        32'd0};
    vecs[7]  = '{"and",          AND_,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[8]  = '{"or",           OR_,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
    vecs[9]  = '{"xor",          XOR_,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    vecs[10] = '{"passb",        PASSB, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFF00FF00};
    vecs[11] = '{"sltu_1_m1",    SLTU,  32'd1,        32'hFFFFFFFF, 32'd1};
    vecs[12] = '{"slt_1_m1",     SLT,   32'd1,        32'hFFFFFFFF, 32'd0};
    vecs[13] = '{"sub_big",      SUB,   32'h12345678, 32'h02345679, 32'h0FFFFFFF};

    w_rst = 1'b1; w_start = 1'b0; w_op = '0; w_a = '0; w_b = '0;
    repeat (2) @(posedge w_clk);
    #1;
    w_rst = 1'b0;
    check("reset_busy", {31'b0, w_busy}, 32'd0);
    check("reset_done", {31'b0, r_done}, 32'd0);
    check("reset_rslt", r_rslt, 32'd0);

    // Table-driven vectors: result, 33-edge latency, single-cycle done
    for (int v = 0; v < 14; v++) begin
      do_op(vecs[v].op, vecs[v].a, vecs[v].b, lat, res);
      check({vecs[v].name, "_rslt"}, res, vecs[v].exp);
      check({vecs[v].name, "_lat"}, lat, 33);
      @(posedge w_clk); #1;
      check({vecs[v].name, "_done_w"}, {31'b0, r_done}, 32'd0);
    end

    // Start while busy is ignored
    w_op = ADD; w_a = 32'd1; w_b = 32'd1; w_start = 1'b1;
    @(posedge w_clk); #1;
    w_start = 1'b0;
    pulses = 0; busy_bad = 0; lat = 0; res = '0;
    for (int i = 1; i <= 70; i++) begin
      if (i == 10) begin
        w_op = SUB; w_a = 32'd100; w_b = 32'd7; w_start = 1'b1;
      end
      @(posedge w_clk); #1;
      if (i == 10) w_start = 1'b0;
      if (i <= 33 && (w_busy !== 1'b1) && i != 33) busy_bad++;
      if (r_done) begin
        pulses++;
        if (lat == 0) begin lat = i; res = r_rslt; end
      end
    end
    check("busy_ign_rslt", res, 32'd2);
    check("busy_ign_lat", lat, 33);
    check("busy_ign_pulses", pulses, 1);
    check("busy_ign_busy", busy_bad, 0);

    // Reset mid-operation (start asserted alongside reset must be ignored)
    w_op = ADD; w_a = 32'h100; w_b = 32'h200; w_start = 1'b1;
    @(posedge w_clk); #1;
    w_start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge w_clk); #1;
    end
    w_rst = 1'b1; w_start = 1'b1;
    @(posedge w_clk); #1;
    w_rst = 1'b0; w_start = 1'b0;
    check("rst_mid_busy", {31'b0, w_busy}, 32'd0);
    check("rst_mid_rslt", r_rslt, 32'd0);
    check("rst_mid_done", {31'b0, r_done}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge w_clk); #1;
      if (r_done || w_busy) pulses++;
    end
    check("rst_mid_quiet", pulses, 0);
    do_op(ADD, 32'd2, 32'd3, lat, res);
    check("post_rst_rslt", res, 32'd5);
    check("post_rst_lat", lat, 33);
    @(posedge w_clk); #1;

    // Back-to-back with start held high
    w_op = XOR_; w_a = 32'hAAAAAAAA; w_b = 32'h55555555; w_start = 1'b1;
    @(posedge w_clk); #1;
    lat = 0; lat2 = 0; res = '0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge w_clk); #1;
      if (r_done) begin
        if (lat == 0) begin
          lat = i;
          check("b2b_first_rslt", r_rslt, 32'hFFFFFFFF);
          check("b2b_busy_in_done", {31'b0, w_busy}, 32'd0);
          w_op = ADD; w_a = 32'd10; w_b = 32'd20;
        end else begin
          lat2 = i;
          res = r_rslt;
          w_start = 1'b0;
          break;
        end
      end
    end
    w_start = 1'b0;
    check("b2b_first_lat", lat, 33);
    check("b2b_spacing", lat2 - lat, 34);
    check("b2b_second_rslt", res, 32'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
